// File: rtl/gcd_ctrl.sv
// gcd_ctrl: control FSM for the 16-bit subtract-and-compare GCD datapath.
// It sequences operand loads, drives repeated subtraction until the operands
// are equal, and hands the result back through a return-to-zero start/done
// handshake. An iteration counter with a ceiling turns runs that never reach
// equality (for example a zero operand) into a timeout.
module gcd_ctrl #(
  parameter logic [15:0] MAX_ITER = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        gt,
  input  logic        lt,
  input  logic        eq,
  output logic        lda,
  output logic        ldb,
  output logic        sel1,
  output logic        sel2,
  output logic        selin,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] iter_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CMP,
    SUB_A,
    SUB_B,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic   cnt_at_max;

  assign cnt_at_max = (iter_cnt == MAX_ITER);

  // State register; reset wins over any transition, even mid-run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and Moore control outputs taken from the state alone.
  always_comb begin
    next_state = state;
    lda        = 1'b0;
    ldb        = 1'b0;
    sel1       = 1'b0;
    sel2       = 1'b0;
    selin      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = LOAD_A;
        end
      end
      LOAD_A: begin
        lda        = 1'b1;
        busy       = 1'b1;
        next_state = LOAD_B;
      end
      LOAD_B: begin
        ldb        = 1'b1;
        busy       = 1'b1;
        next_state = CMP;
      end
      CMP: begin
        busy = 1'b1;
        if (eq) begin
          next_state = DONE;
        end else if (cnt_at_max) begin
          next_state = DONE;
        end else if (gt) begin
          next_state = SUB_A;
        end else if (lt) begin
          next_state = SUB_B;
        end
      end
      SUB_A: begin
        sel1       = 1'b1;
        selin      = 1'b1;
        lda        = 1'b1;
        busy       = 1'b1;
        next_state = CMP;
      end
      SUB_B: begin
        sel2       = 1'b1;
        selin      = 1'b1;
        ldb        = 1'b1;
        busy       = 1'b1;
        next_state = CMP;
      end
      DONE: begin
        done = 1'b1;
        if (!start) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Iteration counter and timeout flag: cleared on load, saturating at the
  // ceiling, and held through DONE and IDLE so the host can read them later.
  // A comparison with no flag set still counts, so a broken datapath times out.
  always_ff @(posedge clk) begin
    if (rst) begin
      iter_cnt <= 16'd0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          iter_cnt <= 16'd0;
          timeout  <= 1'b0;
        end
        CMP: begin
          if (!eq) begin
            if (cnt_at_max) begin
              timeout <= 1'b1;
            end else if (!gt && !lt) begin
              iter_cnt <= iter_cnt + 16'd1;
            end
          end
        end
        SUB_A, SUB_B: begin
          if (!cnt_at_max) begin
            iter_cnt <= iter_cnt + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_ctrl.sv
// tb_gcd_ctrl: directed bench for gcd_ctrl. Each controller instance drives a
// small behavioural model of the A/B datapath whose comparator flags feed back
// into the controller. Expected results are hand-computed constants.
module tb_gcd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start_s;
  logic [15:0] data_in;
  logic        use_s;

  // Default-ceiling instance and its datapath model.
  logic        gt, lt, eq, lda, ldb, sel1, sel2, selin, busy, done, timeout;
  logic [15:0] iter_cnt, reg_a, reg_b, sub_out;

  // MAX_ITER = 8 instance and its datapath model.
  logic        gt_s, lt_s, eq_s, lda_s, ldb_s, sel1_s, sel2_s, selin_s;
  logic        busy_s, done_s, timeout_s;
  logic [15:0] iter_cnt_s, reg_a_s, reg_b_s, sub_out_s;

  // Signals of whichever instance is under test.
  logic        m_lda, m_ldb, m_sel1, m_sel2, m_selin, m_busy, m_done, m_timeout;
  logic [15:0] m_iter_cnt, m_reg_a;

  int compared   = 0;
  int mismatched = 0;

  gcd_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .gt(gt), .lt(lt), .eq(eq),
    .lda(lda), .ldb(ldb), .sel1(sel1), .sel2(sel2), .selin(selin),
    .busy(busy), .done(done), .timeout(timeout), .iter_cnt(iter_cnt)
  );

  gcd_ctrl #(.MAX_ITER(16'd8)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .gt(gt_s), .lt(lt_s), .eq(eq_s),
    .lda(lda_s), .ldb(ldb_s), .sel1(sel1_s), .sel2(sel2_s), .selin(selin_s),
    .busy(busy_s), .done(done_s), .timeout(timeout_s), .iter_cnt(iter_cnt_s)
  );

  always #5 clk = ~clk;

  assign sub_out   = (sel1 ? reg_a : reg_b) - (sel2 ? reg_a : reg_b);
  assign gt        = reg_a > reg_b;
  assign lt        = reg_a < reg_b;
  assign eq        = reg_a == reg_b;
  assign sub_out_s = (sel1_s ? reg_a_s : reg_b_s) - (sel2_s ? reg_a_s : reg_b_s);
  assign gt_s      = reg_a_s > reg_b_s;
  assign lt_s      = reg_a_s < reg_b_s;
  assign eq_s      = reg_a_s == reg_b_s;

  // Datapath registers, loaded from the bus the controller selects.
  always_ff @(posedge clk) begin
    if (lda)   reg_a   <= selin   ? sub_out   : data_in;
    if (ldb)   reg_b   <= selin   ? sub_out   : data_in;
    if (lda_s) reg_a_s <= selin_s ? sub_out_s : data_in;
    if (ldb_s) reg_b_s <= selin_s ? sub_out_s : data_in;
  end

  assign m_lda      = use_s ? lda_s      : lda;
  assign m_ldb      = use_s ? ldb_s      : ldb;
  assign m_sel1     = use_s ? sel1_s     : sel1;
  assign m_sel2     = use_s ? sel2_s     : sel2;
  assign m_selin    = use_s ? selin_s    : selin;
  assign m_busy     = use_s ? busy_s     : busy;
  assign m_done     = use_s ? done_s     : done;
  assign m_timeout  = use_s ? timeout_s  : timeout;
  assign m_iter_cnt = use_s ? iter_cnt_s : iter_cnt;
  assign m_reg_a    = use_s ? reg_a_s    : reg_a;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic setStart(input logic v);
    if (use_s) start_s = v;
    else       start   = v;
  endtask

  // One GCD run: start sampled at edge 0, operands on data_in in cycles 1
  // and 2, then wait (bounded) for done. Steps are recorded as 1 = SUB_A,
  // 0 = SUB_B, oldest in the most significant recorded bit.
  task automatic applyStimulus(input string tag, input logic [15:0] a,
                               input logic [15:0] b, input logic hold,
                               input int exp_k, input logic [15:0] exp_gcd,
                               input logic exp_to, output logic [31:0] steps);
    int cyc;
    int nsteps;
    bit got_done;
    @(negedge clk);
    setStart(1'b1);
    @(posedge clk);
    @(negedge clk);
    data_in = a;
    if (!hold) setStart(1'b0);
    checkOutput({tag, " load_a ctl"}, {28'd0, m_lda, m_ldb, m_selin, m_busy}, 32'h9);
    @(posedge clk);
    @(negedge clk);
    data_in = b;
    checkOutput({tag, " load_b ctl"}, {28'd0, m_lda, m_ldb, m_selin, m_busy}, 32'h5);
    cyc      = 2;
    nsteps   = 0;
    steps    = 32'd0;
    got_done = 1'b0;
    while (!got_done && cyc < 200) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (m_done) begin
        got_done = 1'b1;
      end else if (m_sel1 && m_lda && m_selin) begin
        steps = {steps[30:0], 1'b1};
        nsteps++;
      end else if (m_sel2 && m_ldb && m_selin) begin
        steps = {steps[30:0], 1'b0};
        nsteps++;
      end
    end
    checkOutput({tag, " done cycle"}, cyc, 4 + 2 * exp_k);
    checkOutput({tag, " busy in done"}, {31'd0, m_busy}, 32'd0);
    checkOutput({tag, " step count"}, nsteps, exp_k);
    checkOutput({tag, " iter_cnt"}, {16'd0, m_iter_cnt}, {16'd0, 16'(exp_k)});
    checkOutput({tag, " timeout"}, {31'd0, m_timeout}, {31'd0, exp_to});
    checkOutput({tag, " result A"}, {16'd0, m_reg_a}, {16'd0, exp_gcd});
  endtask

  initial begin
    logic [31:0] steps;
    bit found;
    rst     = 1'b1;
    start   = 1'b0;
    start_s = 1'b0;
    data_in = 16'd0;
    use_s   = 1'b0;
    reg_a   = 16'd0;
    reg_b   = 16'd0;
    reg_a_s = 16'd0;
    reg_b_s = 16'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset ctl", {24'd0, lda, ldb, sel1, sel2, selin, busy, done, timeout}, 32'd0);
    checkOutput("reset iter_cnt", {16'd0, iter_cnt}, 32'd0);
    rst = 1'b0;

    applyStimulus("gcd48_18", 16'd48, 16'd18, 1'b0, 4, 16'd6, 1'b0, steps);
    checkOutput("gcd48_18 step order", steps, 32'b1101);
    @(posedge clk);
    @(negedge clk);
    checkOutput("gcd48_18 back to idle", {30'd0, done, busy}, 32'd0);

    applyStimulus("gcd7_7", 16'd7, 16'd7, 1'b0, 0, 16'd7, 1'b0, steps);

    applyStimulus("gcd13_1", 16'd13, 16'd1, 1'b0, 12, 16'd1, 1'b0, steps);
    checkOutput("gcd13_1 step order", steps, 32'hFFF);

    use_s = 1'b1;
    applyStimulus("zero_b", 16'd5, 16'd0, 1'b0, 8, 16'd5, 1'b1, steps);
    checkOutput("zero_b step order", steps, 32'hFF);
    use_s = 1'b0;

    // Held start keeps DONE; dropping it returns to IDLE with counts retained.
    applyStimulus("hold", 16'd48, 16'd18, 1'b1, 4, 16'd6, 1'b0, steps);
    repeat (3) @(negedge clk);
    checkOutput("hold done stays", {30'd0, done, busy}, 32'h2);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("hold release done", {31'd0, done}, 32'd0);
    checkOutput("hold idle iter_cnt", {16'd0, iter_cnt}, 32'd4);
    applyStimulus("rerun7_7", 16'd7, 16'd7, 1'b0, 0, 16'd7, 1'b0, steps);
    @(posedge clk);

    // Reset in the middle of a run, caught in SUB_A.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_in = 16'd48;
    start   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    data_in = 16'd18;
    found   = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (sel1 && lda) found = 1'b1;
    end
    checkOutput("midrun reached sub_a", {31'd0, found}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrun reset ctl", {24'd0, lda, ldb, sel1, sel2, selin, busy, done, timeout}, 32'd0);
    checkOutput("midrun reset iter_cnt", {16'd0, iter_cnt}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrun stays idle", {29'd0, lda, ldb, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gcd_ctrl.md
# gcd_ctrl

Control FSM for the 16-bit subtract-and-compare GCD datapath. It takes the datapath comparator flags (`gt`, `lt`, `eq`) and drives the datapath controls (`lda`, `ldb`, `sel1`, `sel2`, `selin`). It sequences operand loading from `data_in`, then issues repeated subtraction until the operands are equal. It also reports completion to the host with a start/done handshake, an iteration count, and a timeout flag for non-terminating inputs such as a zero operand.

## Interface
- `MAX_ITER`, default 16'hFFFF: subtraction-step limit before `timeout` is declared; must be >= 1.
- `clk`  in  1  clock; all state updates occur on the rising edge.
- `rst`  in  1  synchronous active-high reset, sampled on the rising edge of `clk`.
- `start`  in  1  host request, level; acted on only in IDLE.
- `gt`  in  1  datapath flag: A > B.
- `lt`  in  1  datapath flag: A < B.
- `eq`  in  1  datapath flag: A == B.
- `lda`  out  1  load register A from bus.
- `ldb`  out  1  load register B from bus.
- `sel1`  out  1  subtractor minuend select: 1 = A, 0 = B.
- `sel2`  out  1  subtractor subtrahend select: 1 = A, 0 = B.
- `selin`  out  1  bus select: 1 = subtractor output, 0 = `data_in`.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  result valid; register A (= B) holds the GCD.
- `timeout`  out  1  valid only with `done`; the run was aborted at `MAX_ITER`.
- `iter_cnt`  out  16  number of subtraction steps in the current or last run.

## Operation
- States: IDLE, LOAD_A, LOAD_B, CMP, SUB_A, SUB_B, DONE.
- All control outputs are Moore outputs, decoded from the state register only.
- Any control output not listed for a state below is 0 in that state.
- IDLE
  - All control outputs 0.
  - `start`=1 -> LOAD_A; otherwise stay in IDLE.
- LOAD_A
  - `lda`=1, `selin`=0; host holds operand A on `data_in` during this cycle.
  - `iter_cnt` cleared to 0; `timeout` cleared to 0.
  - -> LOAD_B.
- LOAD_B
  - `ldb`=1, `selin`=0; host holds operand B on `data_in`.
  - -> CMP.
- CMP
  - No loads; this cycle lets the comparator settle on the registered values.
  - Flags are decoded with priority `eq` > `gt` > `lt`.
  - `eq` -> DONE with `timeout`=0.
  - Else if `iter_cnt` == `MAX_ITER` -> DONE with `timeout`=1.
  - Else `gt` -> SUB_A.
  - Else `lt` -> SUB_B.
  - No flag set -> stay in CMP and increment `iter_cnt`, so a broken datapath still reaches the timeout.
- SUB_A (A <= A - B)
  - `sel1`=1, `sel2`=0, `selin`=1, `lda`=1.
  - `iter_cnt` += 1.
  - -> CMP.
- SUB_B (B <= B - A)
  - `sel1`=0, `sel2`=1, `selin`=1, `ldb`=1.
  - `iter_cnt` += 1.
  - -> CMP.
- DONE
  - `done`=1; `timeout` and `iter_cnt` held.
  - `start`=0 -> IDLE; while `start` stays 1, remain in DONE.
  - A new run therefore requires `start` to return to 0 (return-to-zero handshake).
- `iter_cnt` saturates at `MAX_ITER` and never wraps.
- `iter_cnt` and `timeout` retain their values through IDLE until the next LOAD_A.
- Zero operands (A=0 or B=0 with the other nonzero) never reach `eq`; the run terminates only through `timeout`. A=B=0 completes immediately via `eq`.

## Timing
- Reset: state IDLE; `lda`, `ldb`, `sel1`, `sel2`, `selin`, `busy`, `done`, `timeout` = 0; `iter_cnt` = 0.
- `rst` overrides all transitions, including in the middle of a run; the datapath registers are not cleared by this block.
- Call the edge at which `start` is sampled in IDLE cycle 0.
  - LOAD_A occupies cycle 1; LOAD_B occupies cycle 2; the first CMP is cycle 3.
- For k subtraction steps, `done` first rises in cycle 4 + 2k.
- `busy` is high in cycles 1 through 3 + 2k.
- `done` falls one cycle after `start` is sampled low in DONE.
- `data_in` must be stable across the rising edge that ends LOAD_A (operand A) and the edge that ends LOAD_B (operand B).
- `gt`/`lt`/`eq` are sampled only in CMP and are ignored in all other states.

## Test plan
- GCD(48,18): `start` pulsed high, A=48 and B=18 presented in the load cycles -> step sequence SUB_A, SUB_A, SUB_B, SUB_A; `done` in cycle 12; `iter_cnt`=4; `timeout`=0; A=6.
- GCD(7,7) -> no SUB states; `done` in cycle 4; `iter_cnt`=0.
- GCD(13,1) -> 12 consecutive SUB_A steps; `done` in cycle 28; `iter_cnt`=12; A=1.
- `MAX_ITER`=8, A=5, B=0 -> 8 SUB_A steps, then DONE with `timeout`=1 and `iter_cnt`=8.
- Hold `start`=1 across DONE -> `done` stays high with no restart; drop `start` -> IDLE the next cycle; raise `start` again -> a fresh run with `iter_cnt` cleared.
- Assert `rst` in the middle of a run (in SUB_A) -> the next cycle shows IDLE, all outputs 0, and no `lda`/`ldb` pulse.
